// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer.
//   tdm_state_e : framing FSM states (HUNT searches for sync, LOCKED tracks slots)
//   NUM_SLOTS   : slots per frame
//   SLOT_W      : width of the slot index
package tdm_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

endpackage : tdm_pkg

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM demultiplexer.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : advance the slot index by one (natural 2-bit wrap)
//   load1      : slot 0 was just captured, next expected slot is 1
//   clr        : return to slot 0
//   slot       : registered slot index expected on the next enabled cycle
// Priority: clr > load1 > inc > hold.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load1,
    input  logic              clr,
    output logic [SLOT_W-1:0] slot
);

    // Slot index register with clear / load-to-1 / increment controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= {SLOT_W{1'b0}};
        end else if (clr) begin
            slot <= {SLOT_W{1'b0}};
        end else if (load1) begin
            slot <= SLOT_W'(1);
        end else if (inc) begin
            slot <= slot + SLOT_W'(1);
        end else begin
            slot <= slot;
        end
    end

endmodule : tdm_slot_counter

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: recovers the slot index from a sync-marked
// stream and publishes complete frames on four channel registers.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   din          : multiplexed slot data, sampled when en=1
//   sync         : marks the slot-0 sample of a frame (qualified by en)
//   en           : one slot consumed per cycle with en=1
//   o0..o3       : channel data of the last complete frame
//   s            : slot index expected on the next enabled cycle
//   valid        : one-cycle pulse when o0..o3 are updated
//   locked       : high while the framing FSM is LOCKED
//   sync_err     : one-cycle pulse on a missing or early sync
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  din,
    input  logic              sync,
    input  logic              en,
    output logic [WIDTH-1:0]  o0,
    output logic [WIDTH-1:0]  o1,
    output logic [WIDTH-1:0]  o2,
    output logic [WIDTH-1:0]  o3,
    output logic [SLOT_W-1:0] s,
    output logic              valid,
    output logic              locked,
    output logic              sync_err
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    tdm_state_e       state_r;
    tdm_state_e       next_state_s;
    logic [WIDTH-1:0] shadow0_r;
    logic [WIDTH-1:0] shadow1_r;
    logic [WIDTH-1:0] shadow2_r;
    logic             cap0_s;
    logic             cap1_s;
    logic             cap2_s;
    logic             publish_s;
    logic             err_s;
    logic             cnt_inc_s;
    logic             cnt_load_s;
    logic             cnt_clr_s;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc_s),
        .load1 (cnt_load_s),
        .clr   (cnt_clr_s),
        .slot  (s)
    );

    // Framing FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Framing FSM next state and per-cycle datapath controls
    always_comb begin
        next_state_s = state_r;
        cap0_s       = 1'b0;
        cap1_s       = 1'b0;
        cap2_s       = 1'b0;
        publish_s    = 1'b0;
        err_s        = 1'b0;
        cnt_inc_s    = 1'b0;
        cnt_load_s   = 1'b0;
        cnt_clr_s    = 1'b0;
        if (en) begin
            case (state_r)
                ST_HUNT: begin
                    if (sync) begin
                        cap0_s       = 1'b1;
                        cnt_load_s   = 1'b1;
                        next_state_s = ST_LOCKED;
                    end else begin
                        cnt_clr_s = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (sync) begin
                        // A sync anywhere but slot 0 (slot 3 included) restarts
                        // the frame and suppresses any pending publish.
                        cap0_s     = 1'b1;
                        cnt_load_s = 1'b1;
                        if (s != {SLOT_W{1'b0}}) begin
                            err_s = 1'b1;
                        end else begin
                            err_s = 1'b0;
                        end
                    end else if (s == {SLOT_W{1'b0}}) begin
                        err_s        = 1'b1;
                        cnt_clr_s    = 1'b1;
                        next_state_s = ST_HUNT;
                    end else if (s == LAST_SLOT) begin
                        publish_s = 1'b1;
                        cnt_inc_s = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                        if (s == SLOT_W'(1)) begin
                            cap1_s = 1'b1;
                        end else begin
                            cap2_s = 1'b1;
                        end
                    end
                end
                default: begin
                    next_state_s = ST_HUNT;
                    cnt_clr_s    = 1'b1;
                end
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Shadow registers collecting slots 0..2 of the frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow0_r <= {WIDTH{1'b0}};
            shadow1_r <= {WIDTH{1'b0}};
            shadow2_r <= {WIDTH{1'b0}};
        end else begin
            if (cap0_s) begin
                shadow0_r <= din;
            end else begin
                shadow0_r <= shadow0_r;
            end
            if (cap1_s) begin
                shadow1_r <= din;
            end else begin
                shadow1_r <= shadow1_r;
            end
            if (cap2_s) begin
                shadow2_r <= din;
            end else begin
                shadow2_r <= shadow2_r;
            end
        end
    end

    // Published channel registers and status strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o0       <= {WIDTH{1'b0}};
            o1       <= {WIDTH{1'b0}};
            o2       <= {WIDTH{1'b0}};
            o3       <= {WIDTH{1'b0}};
            valid    <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (publish_s) begin
                // Slot 3 goes straight from din; it never sits in a shadow.
                o0 <= shadow0_r;
                o1 <= shadow1_r;
                o2 <= shadow2_r;
                o3 <= din;
            end else begin
                o0 <= o0;
                o1 <= o1;
                o2 <= o2;
                o3 <= o3;
            end
            valid    <= publish_s;
            locked   <= (next_state_s == ST_LOCKED);
            sync_err <= err_s;
        end
    end

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=1). Expected outputs are packed as
// {o0,o1,o2,o3, s[1:0], valid, locked, sync_err}.
module tb_tdm_demux4;

    typedef struct packed {
        logic       en;
        logic       sync;
        logic       din;
        logic [8:0] exp;
    } vec_t;

    localparam int NVEC = 30;

    logic       clk;
    logic       rst_n;
    logic [0:0] din;
    logic       sync;
    logic       en;
    logic [0:0] o0;
    logic [0:0] o1;
    logic [0:0] o2;
    logic [0:0] o3;
    logic [1:0] s;
    logic       valid;
    logic       locked;
    logic       sync_err;

    int   total;
    int   bad;
    vec_t vecs [NVEC];

    tdm_demux4 #(.WIDTH(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .sync     (sync),
        .en       (en),
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .s        (s),
        .valid    (valid),
        .locked   (locked),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic sy, input logic d,
                                input logic [3:0] o, input logic [1:0] sl,
                                input logic v, input logic l, input logic er);
        vec_t r;
        r.en   = e;
        r.sync = sy;
        r.din  = d;
        r.exp  = {o, sl, v, l, er};
        return r;
    endfunction

    function automatic logic [8:0] observed();
        return {o0, o1, o2, o3, s, valid, locked, sync_err};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got   = observed();
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got {o0..o3,s,v,l,e}=%b_%b_%b%b%b expected %b_%b_%b%b%b",
                     name, got[8:5], got[4:3], got[2], got[1], got[0],
                     exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input logic e, input logic sy, input logic d);
        en   = e;
        sync = sy;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        sync  = 1'b0;
        din   = 1'b0;

        // Hunt: no sync, din ignored
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        // Basic frame 1,0,1,1
        vecs[3]  = mk(1'b1, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b1, 4'b1011, 2'd0, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 4'b1011, 2'd0, 1'b0, 1'b1, 1'b0);
        // Gapped enable between slots 1 and 2; en=0 ignores sync/din
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 4'b1011, 2'd1, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 4'b1011, 2'd2, 1'b0, 1'b1, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 1'b1, 4'b1011, 2'd3, 1'b0, 1'b1, 1'b0);
        vecs[13] = mk(1'b1, 1'b0, 1'b1, 4'b1011, 2'd0, 1'b1, 1'b1, 1'b0);
        // Early sync at s=2, then frame 0,1,1,0
        vecs[14] = mk(1'b1, 1'b1, 1'b1, 4'b1011, 2'd1, 1'b0, 1'b1, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 4'b1011, 2'd1, 1'b0, 1'b1, 1'b1);
        vecs[17] = mk(1'b1, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b0, 1'b1, 1'b0);
        vecs[18] = mk(1'b1, 1'b0, 1'b1, 4'b1011, 2'd3, 1'b0, 1'b1, 1'b0);
        vecs[19] = mk(1'b1, 1'b0, 1'b0, 4'b0110, 2'd0, 1'b1, 1'b1, 1'b0);
        // Missing sync at s=0 drops to hunt, outputs kept
        vecs[20] = mk(1'b1, 1'b0, 1'b1, 4'b0110, 2'd0, 1'b0, 1'b0, 1'b1);
        vecs[21] = mk(1'b1, 1'b0, 1'b0, 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0);
        // Relock, then sync coinciding with slot 3 (early sync, no publish)
        vecs[22] = mk(1'b1, 1'b1, 1'b0, 4'b0110, 2'd1, 1'b0, 1'b1, 1'b0);
        vecs[23] = mk(1'b1, 1'b0, 1'b0, 4'b0110, 2'd2, 1'b0, 1'b1, 1'b0);
        vecs[24] = mk(1'b1, 1'b0, 1'b0, 4'b0110, 2'd3, 1'b0, 1'b1, 1'b0);
        vecs[25] = mk(1'b1, 1'b1, 1'b1, 4'b0110, 2'd1, 1'b0, 1'b1, 1'b1);
        vecs[26] = mk(1'b1, 1'b0, 1'b0, 4'b0110, 2'd2, 1'b0, 1'b1, 1'b0);
        vecs[27] = mk(1'b1, 1'b0, 1'b1, 4'b0110, 2'd3, 1'b0, 1'b1, 1'b0);
        vecs[28] = mk(1'b1, 1'b0, 1'b0, 4'b1010, 2'd0, 1'b1, 1'b1, 1'b0);
        vecs[29] = mk(1'b0, 1'b0, 1'b0, 4'b1010, 2'd0, 1'b0, 1'b1, 1'b0);

        // Reset held for two cycles
        @(posedge clk);
        #1;
        check("reset_c1", 9'b0);
        @(posedge clk);
        #1;
        check("reset_c2", 9'b0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 9'b0);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].en, vecs[i].sync, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Asynchronous reset mid-frame at s=2
        apply(1'b1, 1'b1, 1'b1);
        check("pre_rst_s1", {4'b1010, 2'd1, 1'b0, 1'b1, 1'b0});
        apply(1'b1, 1'b0, 1'b1);
        check("pre_rst_s2", {4'b1010, 2'd2, 1'b0, 1'b1, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_immediate", 9'b0);
        @(posedge clk);
        #1;
        check("async_rst_held", 9'b0);
        #2;
        rst_n = 1'b1;
        apply(1'b1, 1'b0, 1'b1);
        check("rst_release_hunt1", 9'b0);
        apply(1'b1, 1'b0, 1'b1);
        check("rst_release_hunt2", 9'b0);
        apply(1'b1, 1'b1, 1'b0);
        check("new_frame_s1", {4'b0000, 2'd1, 1'b0, 1'b1, 1'b0});
        apply(1'b1, 1'b0, 1'b1);
        check("new_frame_s2", {4'b0000, 2'd2, 1'b0, 1'b1, 1'b0});
        apply(1'b1, 1'b0, 1'b1);
        check("new_frame_s3", {4'b0000, 2'd3, 1'b0, 1'b1, 1'b0});
        apply(1'b1, 1'b0, 1'b1);
        check("new_frame_pub", {4'b0111, 2'd0, 1'b1, 1'b1, 1'b0});
        apply(1'b0, 1'b0, 1'b0);
        check("new_frame_valid_drop", {4'b0111, 2'd0, 1'b0, 1'b1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tdm_demux4
